// File: rtl/dest_track_pipe_pkg.sv
// Shared definitions for the destination-tracking pipeline.
//   REG_W_DEF / CNT_W_DEF : default register-index and stall-counter widths
//   stage_t               : per-stage record {dest, wb_en, mem_r_en}
//   BUBBLE                : empty stage (no write, no load)
//   mk_stage              : builds a stage record from ID fields
package dest_track_pipe_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [REG_W_DEF-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic stage_t mk_stage(input logic [REG_W_DEF-1:0] dest,
                                      input logic wb_en,
                                      input logic mem_r_en);
    stage_t s;
    s.dest     = dest;
    s.wb_en    = wb_en;
    s.mem_r_en = mem_r_en;
    return s;
  endfunction

endpackage

// File: rtl/dest_track_pipe_hazard_cmp.sv
// Combinational read-after-write comparator. Compares the ID sources against
// two older-stage destinations, each qualified by its own enable. The caller
// picks the enables, so one instance serves both forwarding modes.
//   src1_i, src2_i : ID source registers
//   two_src_i      : src2_i is really read
//   dest_a_i/en_a_i, dest_b_i/en_b_i : candidate producers and their enables
//   raw_o          : at least one source matches an enabled producer
module dest_track_pipe_hazard_cmp
  import dest_track_pipe_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter bit IGNORE_R0 = 1'b0
) (
  input  logic [REG_W-1:0] src1_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             two_src_i,
  input  logic [REG_W-1:0] dest_a_i,
  input  logic             en_a_i,
  input  logic [REG_W-1:0] dest_b_i,
  input  logic             en_b_i,
  output logic             raw_o
);

  function automatic logic match(input logic [REG_W-1:0] s,
                                 input logic [REG_W-1:0] d,
                                 input logic en);
    return en && (s == d) && !(IGNORE_R0 && (s == '0));
  endfunction

  logic hit_src1;
  logic hit_src2;

  always_comb begin
    hit_src1 = match(src1_i, dest_a_i, en_a_i) | match(src1_i, dest_b_i, en_b_i);
    hit_src2 = match(src2_i, dest_a_i, en_a_i) | match(src2_i, dest_b_i, en_b_i);
    raw_o    = hit_src1 | (two_src_i & hit_src2);
  end

endmodule

// File: rtl/dest_track_pipe.sv
// Producer side of the forwarding interface. Carries the destination register
// and write/load flags of each issued instruction through EXE, MEM and WB,
// raises hazard_stall for RAW hazards forwarding cannot cover, and counts
// stall cycles (saturating).
//   clk, rst (async, active-low)
//   id_*              : ID-stage instruction fields
//   forward_en        : forwarding active (only load-use stalls remain)
//   mem_freeze        : hold EXE/MEM/WB and the stall counter
//   flush             : discard the ID instruction
//   Dest_*/WB_EN_*/MEM_R_EN_* : per-stage values for the forwarding detector
//   hazard_stall      : combinational stall request toward IF/ID
//   stall_cnt         : saturating count of non-frozen stall cycles
// The stage record width is fixed by the shared package, so REG_W must stay
// at REG_W_DEF.
module dest_track_pipe
  import dest_track_pipe_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter bit IGNORE_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             forward_en,
  input  logic             mem_freeze,
  input  logic             flush,
  output logic [REG_W-1:0] Dest_EXE,
  output logic [REG_W-1:0] Dest_MEM,
  output logic [REG_W-1:0] Dest_WB,
  output logic             WB_EN_EXE,
  output logic             WB_EN_MEM,
  output logic             WB_EN_WB,
  output logic             MEM_R_EN_EXE,
  output logic             MEM_R_EN_MEM,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_t             exe_q, exe_d;
  stage_t             mem_q, mem_d;
  logic [REG_W-1:0]   wb_dest_q, wb_dest_d;
  logic               wb_en_q, wb_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               en_exe;
  logic               en_mem;
  logic               raw_hazard;

  // With forwarding only a load in EXE is uncoverable; without it any
  // writer in EXE or MEM is. WB is never a hazard (write-before-read RF).
  assign en_exe = exe_q.wb_en & (exe_q.mem_r_en | ~forward_en);
  assign en_mem = mem_q.wb_en & ~forward_en;

  dest_track_pipe_hazard_cmp #(
    .REG_W     (REG_W),
    .IGNORE_R0 (IGNORE_R0)
  ) u_hazard_cmp (
    .src1_i    (id_src1),
    .src2_i    (id_src2),
    .two_src_i (id_two_src),
    .dest_a_i  (exe_q.dest),
    .en_a_i    (en_exe),
    .dest_b_i  (mem_q.dest),
    .en_b_i    (en_mem),
    .raw_o     (raw_hazard)
  );

  always_comb begin
    hazard_stall = raw_hazard & id_valid & ~flush;
    exe_d        = exe_q;
    mem_d        = mem_q;
    wb_dest_d    = wb_dest_q;
    wb_en_d      = wb_en_q;
    cnt_d        = cnt_q;
    if (!mem_freeze) begin
      if (hazard_stall || flush || !id_valid) begin
        exe_d = BUBBLE;
      end else begin
        exe_d = mk_stage(id_dest, id_wb_en, id_mem_r_en);
      end
      mem_d     = exe_q;
      wb_dest_d = mem_q.dest;
      wb_en_d   = mem_q.wb_en;
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q     <= BUBBLE;
      mem_q     <= BUBBLE;
      wb_dest_q <= '0;
      wb_en_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      exe_q     <= exe_d;
      mem_q     <= mem_d;
      wb_dest_q <= wb_dest_d;
      wb_en_q   <= wb_en_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Dest_EXE     = exe_q.dest;
  assign Dest_MEM     = mem_q.dest;
  assign Dest_WB      = wb_dest_q;
  assign WB_EN_EXE    = exe_q.wb_en;
  assign WB_EN_MEM    = mem_q.wb_en;
  assign WB_EN_WB     = wb_en_q;
  assign MEM_R_EN_EXE = exe_q.mem_r_en;
  assign MEM_R_EN_MEM = mem_q.mem_r_en;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Bench for dest_track_pipe. Two instances share the stimulus: one with the
// default parameters, one with CNT_W=2 and IGNORE_R0=1. A reference model
// keeps each instance's in-flight instructions as a small array of records;
// expectations are queued per cycle and popped by an independent monitor.
module tb_dest_track_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic       forward_en;
  logic       mem_freeze;
  logic       flush;

  logic [4:0]  a_dexe, a_dmem, a_dwb, b_dexe, b_dmem, b_dwb;
  logic        a_wexe, a_wmem, a_wwb, a_rexe, a_rmem, a_haz;
  logic        b_wexe, b_wmem, b_wwb, b_rexe, b_rmem, b_haz;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  dest_track_pipe u_dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .forward_en(forward_en),
    .mem_freeze(mem_freeze), .flush(flush),
    .Dest_EXE(a_dexe), .Dest_MEM(a_dmem), .Dest_WB(a_dwb),
    .WB_EN_EXE(a_wexe), .WB_EN_MEM(a_wmem), .WB_EN_WB(a_wwb),
    .MEM_R_EN_EXE(a_rexe), .MEM_R_EN_MEM(a_rmem),
    .hazard_stall(a_haz), .stall_cnt(a_cnt)
  );

  dest_track_pipe #(.REG_W(5), .CNT_W(2), .IGNORE_R0(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .forward_en(forward_en),
    .mem_freeze(mem_freeze), .flush(flush),
    .Dest_EXE(b_dexe), .Dest_MEM(b_dmem), .Dest_WB(b_dwb),
    .WB_EN_EXE(b_wexe), .WB_EN_MEM(b_wmem), .WB_EN_WB(b_wwb),
    .MEM_R_EN_EXE(b_rexe), .MEM_R_EN_MEM(b_rmem),
    .hazard_stall(b_haz), .stall_cnt(b_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int dest;
    bit wb;
    bit ld;
  } rec_t;

  rec_t        pipe [2][3];   // [instance][0=EXE,1=MEM,2=WB]
  int unsigned cnt  [2];
  int unsigned cmax [2] = '{65535, 3};
  bit          ign  [2] = '{1'b0, 1'b1};

  typedef struct packed {
    logic        h;
    logic [15:0] c;
    logic [19:0] st;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } exp2_t;

  exp2_t sb_q [$];

  int total = 0;
  int bad   = 0;

  function automatic bit hits(int m, int s, int d);
    return (s == d) && !(ign[m] && s == 0);
  endfunction

  // A stall is needed when a source is produced by an older instruction whose
  // value is not yet obtainable: only loads in EXE when forwarding, any writer
  // in EXE or MEM when not.
  function automatic bit m_haz(int m);
    int depth;
    if (!id_valid || flush) return 1'b0;
    depth = forward_en ? 1 : 2;
    for (int k = 0; k < depth; k++) begin
      if (pipe[m][k].wb && (!forward_en || pipe[m][k].ld)) begin
        if (hits(m, int'(id_src1), pipe[m][k].dest)) return 1'b1;
        if (id_two_src && hits(m, int'(id_src2), pipe[m][k].dest)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void m_clear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) pipe[m][k] = '{0, 1'b0, 1'b0};
      cnt[m] = 0;
    end
  endfunction

  function automatic exp_t m_exp(int m);
    exp_t e;
    e.h  = m_haz(m);
    e.c  = 16'(cnt[m]);
    e.st = {5'(pipe[m][0].dest), 5'(pipe[m][1].dest), 5'(pipe[m][2].dest),
            pipe[m][0].wb, pipe[m][1].wb, pipe[m][2].wb,
            pipe[m][0].ld, pipe[m][1].ld};
    return e;
  endfunction

  function automatic void m_clock();
    bit h;
    if (!rst) begin
      m_clear();
      return;
    end
    if (mem_freeze) return;
    for (int m = 0; m < 2; m++) begin
      h = m_haz(m);
      pipe[m][2] = pipe[m][1];
      pipe[m][1] = pipe[m][0];
      if (h || flush || !id_valid) pipe[m][0] = '{0, 1'b0, 1'b0};
      else pipe[m][0] = '{int'(id_dest), id_wb_en, id_mem_r_en};
      if (h && cnt[m] < cmax[m]) cnt[m]++;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp2_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("a_stall", 32'(a_haz), 32'(e.a.h));
        chk("a_cnt", 32'(a_cnt), 32'(e.a.c));
        chk("a_stages", 32'({a_dexe, a_dmem, a_dwb, a_wexe, a_wmem, a_wwb, a_rexe, a_rmem}),
            32'(e.a.st));
        chk("b_stall", 32'(b_haz), 32'(e.b.h));
        chk("b_cnt", 32'(b_cnt), 32'(e.b.c));
        chk("b_stages", 32'({b_dexe, b_dmem, b_dwb, b_wexe, b_wmem, b_wwb, b_rexe, b_rmem}),
            32'(e.b.st));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit v, input int d, input bit wb, input bit ld,
                        input int s1, input int s2, input bit two,
                        input bit fwd, input bit frz, input bit fl);
    exp2_t e;
    id_valid    = v;
    id_dest     = 5'(d);
    id_wb_en    = wb;
    id_mem_r_en = ld;
    id_src1     = 5'(s1);
    id_src2     = 5'(s2);
    id_two_src  = two;
    forward_en  = fwd;
    mem_freeze  = frz;
    flush       = fl;
    if (!rst) m_clear();
    e.a = m_exp(0);
    e.b = m_exp(1);
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle(input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, fwd, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin : stim
    int saved;
    rst = 1'b0;
    m_clear();
    @(posedge clk);
    #1;

    // Reset held while an instruction is presented.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 7, 1'b1, 1'b1, 7, 7, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      chk("rst_stall", 32'(a_haz), 0);
      chk("rst_stages", 32'({a_dexe, a_dmem, a_dwb, a_wexe, a_wmem, a_wwb, a_rexe, a_rmem}), 0);
      chk("rst_cnt", 32'(a_cnt), 0);
      step();
    end
    rst = 1'b1;
    idle(3, 1'b0);
    chk("post_rst_stages", 32'({a_dexe, a_dmem, a_dwb, a_wexe, a_wmem, a_wwb, a_rexe, a_rmem}), 0);
    chk("post_rst_cnt", 32'(a_cnt), 0);

    // Load-use with forwarding: one bubble, then the consumer proceeds.
    set_in(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b1, 6, 1'b1, 1'b0, 5, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 chk("lu_stall", 32'(a_haz), 1);
    step();
    set_in(1'b1, 6, 1'b1, 1'b0, 5, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("lu_clear", 32'(a_haz), 0);
    chk("lu_bubble", 32'(a_dexe), 0);
    chk("lu_ld_in_mem", 32'({a_dmem, a_rmem}), 32'({5'd5, 1'b1}));
    chk("lu_cnt", 32'(a_cnt), 1);
    step();
    chk("lu_add_exe", 32'(a_dexe), 6);
    idle(3, 1'b1);

    // RAW without forwarding: two stall cycles; none when src2 is unused.
    set_in(1'b1, 3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 8, 1'b1, 1'b0, 7, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 chk("nf_stall", 32'(a_haz), 1);
      step();
    end
    set_in(1'b1, 8, 1'b1, 1'b0, 7, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("nf_release", 32'(a_haz), 0);
    chk("nf_cnt", 32'(a_cnt), 3);
    step();
    idle(3, 1'b0);
    set_in(1'b1, 3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 8, 1'b1, 1'b0, 7, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("nf_one_src", 32'(a_haz), 0);
    step();
    idle(3, 1'b0);

    // Freeze during a load-use stall: everything holds, count unchanged.
    set_in(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    saved = int'(a_cnt);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 6, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2;
      chk("frz_stall", 32'(a_haz), 1);
      chk("frz_dest", 32'({a_dexe, a_dmem, a_dwb}), 32'({5'd5, 5'd0, 5'd0}));
      chk("frz_cnt", 32'(a_cnt), 32'(saved));
      step();
    end
    set_in(1'b1, 6, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("frz_release_cnt", 32'(a_cnt), 32'(saved + 1));
    idle(3, 1'b1);

    // Flush wins over a load-use stall.
    set_in(1'b1, 9, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    saved = int'(a_cnt);
    set_in(1'b1, 6, 1'b1, 1'b0, 9, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2 chk("fl_stall", 32'(a_haz), 0);
    step();
    chk("fl_bubble", 32'({a_dexe, a_wexe}), 0);
    chk("fl_cnt", 32'(a_cnt), 32'(saved));
    idle(3, 1'b1);

    // R0 load-use: stalls the default instance only; narrow counter saturated.
    set_in(1'b1, 0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b1, 6, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("r0_stall_a", 32'(a_haz), 1);
    chk("r0_stall_b", 32'(b_haz), 0);
    step();
    chk("sat_cnt_a", 32'(a_cnt), 5);
    chk("sat_cnt_b", 32'(b_cnt), 3);
    idle(3, 1'b1);

    // Randomized traffic with small register range to force frequent hazards.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      set_in($urandom_range(0, 9) < 8, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b1;
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dest_track_pipe.md
Name: dest_track_pipe

Overview:
- Producer side of the forwarding interface. Carries each issued instruction's destination register and write/read-enable flags from ID through EXE, MEM and WB.
- Drives the Dest/WB_EN/MEM_R_EN values that the forwarding detector consumes.
- Detects read-after-write hazards that forwarding cannot cover and raises a stall toward IF/ID.
- Handles memory freeze, branch flush and a saturating stall-cycle counter.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 16, width of the stall-cycle counter.
- IGNORE_R0, 0, when 1 a source of register 0 never causes a hazard.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_dest  in  REG_W  destination register of the ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_src1  in  REG_W  first source register
- id_src2  in  REG_W  second source register
- id_two_src  in  1  id_src2 is actually read
- forward_en  in  1  forwarding unit active
- mem_freeze  in  1  memory busy; EXE/MEM/WB hold
- flush  in  1  branch taken; ID instruction is discarded
- Dest_EXE, Dest_MEM, Dest_WB  out  REG_W each  per-stage destination
- WB_EN_EXE, WB_EN_MEM, WB_EN_WB  out  1 each  per-stage write enable
- MEM_R_EN_EXE, MEM_R_EN_MEM  out  1 each  per-stage load flag
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - All Dest_* = 0; all WB_EN_* = 0; all MEM_R_EN_* = 0; stall_cnt = 0.
  - hazard_stall is combinational, so it reads 0 while reset is held.
- Bubble: dest=0, wb_en=0, mem_r_en=0.
- Match rule: match(s, D, en) = en & (s == D) & ~(IGNORE_R0 & s == 0).
  - src2 terms apply only when id_two_src = 1.
- Raw hazard, forward_en = 1 (load-use only):
  - match(src1 or src2, Dest_EXE, WB_EN_EXE & MEM_R_EN_EXE).
- Raw hazard, forward_en = 0:
  - match(src, Dest_EXE, WB_EN_EXE) OR match(src, Dest_MEM, WB_EN_MEM).
- WB stage is never checked: the register file writes before it is read in the same cycle.
- hazard_stall = raw_hazard & id_valid & ~flush. It is combinational with zero latency.
- Clock edge with mem_freeze = 1: every stage register holds its value, including stall_cnt.
- Clock edge with mem_freeze = 0:
  - EXE <= bubble if (hazard_stall | flush | ~id_valid), otherwise the ID fields.
  - MEM <= EXE.
  - WB <= MEM.
  - MEM_R_EN propagates EXE -> MEM only; WB carries no load flag.
- Latency: an ID instruction appears in EXE 1 cycle after acceptance, MEM after 2, WB after 3 (non-frozen cycles).
- stall_cnt increments on each edge where hazard_stall = 1 and mem_freeze = 0. It saturates at all-ones with no wrap.
- Simultaneous events:
  - flush and hazard together: flush wins, so stall = 0 and a bubble is inserted.
  - freeze and hazard together: stall output stays asserted and the pipeline holds. The count does not increment.
- A load-use stall clears itself after one non-frozen cycle, because the load moves to MEM.
- Reset mid-operation empties every stage immediately. hazard_stall drops in the same cycle.

Decomposition:
- Shared package: REG_W default, the bubble constant and a stage record typedef {dest, wb_en, mem_r_en}.
- One natural sub-module, hazard_cmp, holding the purely combinational match/raw_hazard logic. It is reused in both forwarding modes.

Test Plan:
- Reset: hold rst=0 while inputs are driven.
  - Required: all outputs 0. Released with id_valid=0 for 3 cycles, outputs stay 0.
- Load-use, forward_en=1: issue LD dest=5, then ADD src1=5.
  - Required: hazard_stall=1 for exactly 1 cycle. EXE then holds a bubble; ADD enters EXE the following cycle; stall_cnt=1.
- No-forward RAW, forward_en=0: ADD dest=3, then SUB src2=3 with two_src=1.
  - Required: stall for 2 cycles. With two_src=0 there is no stall.
- Freeze: assert mem_freeze for 4 cycles during a load-use stall.
  - Required: Dest_EXE/MEM/WB unchanged for all 4 cycles; stall_cnt unchanged; hazard_stall held at 1.
- Flush vs stall: load-use condition together with flush=1.
  - Required: hazard_stall=0, EXE gets a bubble, stall_cnt unchanged.
- Saturation and R0: CNT_W=2 with 5 consecutive stall cycles.
  - Required: stall_cnt=3.
  - IGNORE_R0=1 with a load to dest 0 followed by src1=0: no stall.
